fifo_wr_arbiter: RTL and testbench

Round-robin write-side arbiter that shares the single push port of the async FIFO among NREQ producers in the write clock domain. Each grant is a burst of up to BURSTMAX words, ended early by the producer's last flag or a dropped request. The block drives push/wdata directly into the FIFO's write port and honours its full flag. Read side is untouched.

---
 rtl/fifo_wr_arbiter.sv | 126 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-side arbiter: shares one async-FIFO push port among NREQ
// producers, granting bursts of up to BURSTMAX words per owner.
module fifo_wr_arbiter #(
    parameter  int NREQ     = 4,
    parameter  int DWIDTH   = 8,
    parameter  int BURSTMAX = 4,
    localparam int OW       = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CW       = $clog2(BURSTMAX + 1)
) (
    input  logic                     wclk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*DWIDTH-1:0]   req_data,
    input  logic [NREQ-1:0]          req_last,
    output logic [NREQ-1:0]          gnt,
    output logic                     push,
    output logic [DWIDTH-1:0]        wdata,
    input  logic                     full,
    output logic                     busy,
    output logic [OW-1:0]            owner
);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t          state, next_state;
    logic [OW-1:0]   next_owner;
    logic [OW-1:0]   rr_last, next_rr_last;
    logic [CW-1:0]   cnt, next_cnt;
    logic [CW-1:0]   cnt_inc;

    logic            found;
    logic [OW-1:0]   winner;
    logic [DWIDTH-1:0] owner_data;
    logic            owner_req;
    logic            owner_last;
    logic            accept;

    // Scan starts just after the last served index so every requester gets a turn.
    always_comb begin
        int unsigned rr_u;
        int unsigned idx;
        found  = 1'b0;
        winner = '0;
        rr_u   = 32'(rr_last);
        for (int unsigned i = 1; i <= NREQ; i++) begin
            idx = (rr_u + i) % NREQ;
            if (!found && req[idx[OW-1:0]]) begin
                found  = 1'b1;
                winner = idx[OW-1:0];
            end
        end
    end

    always_comb begin
        owner_data = '0;
        owner_req  = 1'b0;
        owner_last = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (owner == OW'(i)) begin
                owner_data = req_data[i*DWIDTH +: DWIDTH];
                owner_req  = req[i];
                owner_last = req_last[i];
            end
        end
    end

    assign cnt_inc = cnt + CW'(1);

    always_comb begin
        next_state   = state;
        next_owner   = owner;
        next_rr_last = rr_last;
        next_cnt     = cnt;
        accept       = 1'b0;
        push         = 1'b0;
        gnt          = '0;
        wdata        = '0;
        busy         = 1'b0;

        case (state)
            IDLE: begin
                if (found) begin
                    next_owner = winner;
                    next_cnt   = '0;
                    next_state = BURST;
                end
            end
            BURST: begin
                busy   = 1'b1;
                wdata  = owner_data;
                accept = owner_req && !full && !reset;
                if (accept) begin
                    push       = 1'b1;
                    gnt[owner] = 1'b1;
                    next_cnt   = cnt_inc;
                    if (owner_last || cnt_inc == CW'(BURSTMAX)) begin
                        next_state   = IDLE;
                        next_rr_last = owner;
                    end
                end else if (!owner_req) begin
                    next_state   = IDLE;
                    next_rr_last = owner;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge wclk) begin
        if (reset) begin
            state   <= IDLE;
            owner   <= '0;
            rr_last <= OW'(NREQ - 1);
            cnt     <= '0;
        end else begin
            state   <= next_state;
            owner   <= next_owner;
            rr_last <= next_rr_last;
            cnt     <= next_cnt;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NREQ=4, DWIDTH=8, BURSTMAX=4) with
// hand-computed per-cycle expectations.
module tb_fifo_wr_arbiter;

    logic        wclk;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  gnt;
    logic        push;
    logic [7:0]  wdata;
    logic        full;
    logic        busy;
    logic [1:0]  owner;

    int errors = 0;
    int checks = 0;
    logic [7:0] pushed[$];

    fifo_wr_arbiter #(
        .NREQ(4),
        .DWIDTH(8),
        .BURSTMAX(4)
    ) dut (
        .wclk(wclk),
        .reset(reset),
        .req(req),
        .req_data(req_data),
        .req_last(req_last),
        .gnt(gnt),
        .push(push),
        .wdata(wdata),
        .full(full),
        .busy(busy),
        .owner(owner)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    // Words landing in the FIFO, captured on the write edge.
    always @(posedge wclk) begin
        if (push === 1'b1) pushed.push_back(wdata);
    end

    task automatic tick;
        @(posedge wclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic p, input logic [3:0] g,
                              input logic [7:0] wd, input logic b, input logic [1:0] o);
        #1;
        check({tag, ".push"},  32'(push),  32'(p));
        check({tag, ".gnt"},   32'(gnt),   32'(g));
        check({tag, ".wdata"}, 32'(wdata), 32'(wd));
        check({tag, ".busy"},  32'(busy),  32'(b));
        check({tag, ".owner"}, 32'(owner), 32'(o));
    endtask

    initial begin
        int unsigned o;
        int unsigned prev;
        logic [7:0] d;

        reset    = 1'b1;
        req      = '0;
        req_data = '0;
        req_last = '0;
        full     = 1'b0;

        // Reset then idle
        tick;
        expect_out("rst1", 1'b0, 4'b0000, 8'h00, 1'b0, 2'd0);
        tick;
        expect_out("rst2", 1'b0, 4'b0000, 8'h00, 1'b0, 2'd0);
        reset = 1'b0;
        tick;
        expect_out("idle", 1'b0, 4'b0000, 8'h00, 1'b0, 2'd0);

        // Single requester 2, continuous request: two bursts of 4
        req = 4'b0100;
        req_data[2*8 +: 8] = 8'h10;
        expect_out("single_arb", 1'b0, 4'b0000, 8'h00, 1'b0, 2'd0);
        tick;
        for (int b = 0; b < 2; b++) begin
            for (int w = 0; w < 4; w++) begin
                d = 8'(8'h10 + b*4 + w);
                req_data[2*8 +: 8] = d;
                expect_out("single_word", 1'b1, 4'b0100, d, 1'b1, 2'd2);
                tick;
            end
            if (b == 1) req = '0;
            expect_out("single_gap", 1'b0, 4'b0000, 8'h00, 1'b0, 2'd2);
            tick;
        end

        // Round robin with all four requesting
        reset = 1'b1;
        expect_out("rr_rst", 1'b0, 4'b0000, 8'h00, 1'b0, 2'd2);
        tick;
        reset = 1'b0;
        req = 4'b1111;
        req_data = 32'hA3A2A1A0;
        for (int k = 0; k < 5; k++) begin
            o = k % 4;
            prev = (k == 0) ? 0 : (k - 1) % 4;
            expect_out("rr_gap", 1'b0, 4'b0000, 8'h00, 1'b0, 2'(prev));
            tick;
            for (int w = 0; w < 4; w++) begin
                expect_out("rr_word", 1'b1, 4'(1 << o), 8'(8'hA0 + o), 1'b1, 2'(o));
                tick;
            end
        end
        req = '0;
        expect_out("rr_end", 1'b0, 4'b0000, 8'h00, 1'b0, 2'd0);
        tick;

        // Early end by req_last on the second word
        req = 4'b0010;
        req_data = '0;
        req_data[1*8 +: 8] = 8'h51;
        expect_out("last_arb", 1'b0, 4'b0000, 8'h00, 1'b0, 2'd0);
        tick;
        expect_out("last_w0", 1'b1, 4'b0010, 8'h51, 1'b1, 2'd1);
        tick;
        req_data[1*8 +: 8] = 8'h52;
        req_last = 4'b0010;
        expect_out("last_w1", 1'b1, 4'b0010, 8'h52, 1'b1, 2'd1);
        tick;
        req = '0;
        req_last = '0;
        expect_out("last_idle", 1'b0, 4'b0000, 8'h00, 1'b0, 2'd1);
        tick;

        // Early end by dropped request after one word
        req = 4'b0010;
        req_data[1*8 +: 8] = 8'h61;
        expect_out("drop_arb", 1'b0, 4'b0000, 8'h00, 1'b0, 2'd1);
        tick;
        expect_out("drop_w0", 1'b1, 4'b0010, 8'h61, 1'b1, 2'd1);
        tick;
        req = '0;
        expect_out("drop_nopush", 1'b0, 4'b0000, 8'h61, 1'b1, 2'd1);
        tick;
        expect_out("drop_idle", 1'b0, 4'b0000, 8'h00, 1'b0, 2'd1);
        tick;

        // Backpressure: full held 3 cycles on word 0x22
        pushed.delete();
        req = 4'b0001;
        req_data = '0;
        req_data[7:0] = 8'h20;
        expect_out("bp_arb", 1'b0, 4'b0000, 8'h00, 1'b0, 2'd1);
        tick;
        expect_out("bp_w0", 1'b1, 4'b0001, 8'h20, 1'b1, 2'd0);
        tick;
        req_data[7:0] = 8'h21;
        expect_out("bp_w1", 1'b1, 4'b0001, 8'h21, 1'b1, 2'd0);
        tick;
        req_data[7:0] = 8'h22;
        full = 1'b1;
        for (int s = 0; s < 3; s++) begin
            expect_out("bp_stall", 1'b0, 4'b0000, 8'h22, 1'b1, 2'd0);
            tick;
        end
        full = 1'b0;
        expect_out("bp_w2", 1'b1, 4'b0001, 8'h22, 1'b1, 2'd0);
        tick;
        req_data[7:0] = 8'h23;
        expect_out("bp_w3", 1'b1, 4'b0001, 8'h23, 1'b1, 2'd0);
        tick;
        req = '0;
        expect_out("bp_idle", 1'b0, 4'b0000, 8'h00, 1'b0, 2'd0);
        check("bp_count", 32'(pushed.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            d = (i < pushed.size()) ? pushed[i] : 8'hXX;
            check("bp_order", 32'(d), 32'(8'h20 + i));
        end
        tick;

        // Reset mid-burst, then requester 0 must win over 1
        req = 4'b0010;
        req_data = '0;
        req_data[1*8 +: 8] = 8'h71;
        expect_out("mr_arb", 1'b0, 4'b0000, 8'h00, 1'b0, 2'd0);
        tick;
        expect_out("mr_w0", 1'b1, 4'b0010, 8'h71, 1'b1, 2'd1);
        tick;
        req_data[1*8 +: 8] = 8'h72;
        expect_out("mr_w1", 1'b1, 4'b0010, 8'h72, 1'b1, 2'd1);
        tick;
        req_data[1*8 +: 8] = 8'h73;
        reset = 1'b1;
        expect_out("mr_rst", 1'b0, 4'b0000, 8'h73, 1'b1, 2'd1);
        tick;
        reset = 1'b0;
        req = 4'b0011;
        req_data[7:0] = 8'h80;
        expect_out("mr_idle", 1'b0, 4'b0000, 8'h00, 1'b0, 2'd0);
        tick;
        expect_out("mr_first", 1'b1, 4'b0001, 8'h80, 1'b1, 2'd0);
        tick;

        req = '0;
        reset = 1'b1;
        tick;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
